seq_detect_scheduler: RTL and testbench
=======================================

# seq_detect_scheduler

Controller that shares one serial pattern detector among `N_REQ` requesters. Each requester presents a parallel word. The block arbitrates between them, latches the winning word and shifts it MSB-first through the embedded detector. It then reports the number of pattern hits for that word and which requester it came from. It sits between the word-level producers and the bit-serial detection datapath.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `WORD_W`, 8, word width in bits
- `PAT_W`, 4, pattern length (2..`WORD_W`)
- `PATTERN`, 4'b1011, pattern to detect; first-shifted bit is the MSB

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low; sampled on `clock` rising edge
- `req`  in  `N_REQ`  request per requester; held high until granted
- `data`  in  `N_REQ*WORD_W`  word of requester i at `[i*WORD_W +: WORD_W]`; stable while `req[i]` is high
- `grant`  out  `N_REQ`  one-hot, one-cycle accept strobe
- `busy`  out  1  word in flight (SHIFT or REPORT state)
- `bit_out`  out  1  bit currently presented to the detector
- `match`  out  1  current bit completes `PATTERN`
- `done`  out  1  one-cycle result strobe
- `done_id`  out  `$clog2(N_REQ)`  requester index of the reported word
- `hit_count`  out  `$clog2(WORD_W-PAT_W+2)`  hits in the reported word

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: `WORD_W` cycles, one bit per cycle.
  - REPORT: 1 cycle.
- IDLE, `req != 0`:
  - Arbiter picks a winner; `grant[winner]` is driven high combinationally in that cycle.
  - At the edge: latch the word and winner index, clear the bit counter, detector history and `hit_count`, go to SHIFT.
- Arbitration is round-robin. Search starts at `last+1`, wrapping modulo `N_REQ`. `last` updates only on grant.
- SHIFT:
  - `bit_out` = latched word bit `WORD_W-1-k` at bit index k.
  - `match` = ({history[PAT_W-2:0], bit_out} == PATTERN) && k ≥ PAT_W-1.
  - At each edge: history shifts in `bit_out` and `hit_count` increments when `match` is high.
  - Matches may overlap; history never spans two words.
  - After bit k=WORD_W-1, go to REPORT.
- REPORT: `done`=1, `done_id` = winner index. Go to IDLE.
- `hit_count`/`done_id` hold their value until the next grant.
- `grant` is never asserted outside IDLE. Requests arriving during SHIFT/REPORT wait.
- Reset low at an edge, from any state:
  - Go to IDLE and discard the in-flight word; no `done` is produced.
  - `last` = N_REQ-1, so requester 0 has first priority.
- Reset values: `grant`=0, `busy`=0, `bit_out`=0, `match`=0, `done`=0, `done_id`=0, `hit_count`=0, history=0.

## Timing
- Cycle 0 (IDLE, req seen): `grant` high.
- Cycles 1..WORD_W: SHIFT, `busy`=1.
- Cycle WORD_W+1: `done`=1, `busy`=1.
- Cycle WORD_W+2 is IDLE. The earliest next grant is in that cycle, giving throughput 1 word per WORD_W+2 cycles.
- `match` is combinational in the same cycle as the completing bit. The corresponding `hit_count` increment is visible the next cycle.
- `req` dropped before grant: no grant and no side effect.
- Simultaneous requests: exactly one grant per IDLE cycle.

## Configuration
- `SEQ_SCHED_FIXED_PRIO_EN` defined: fixed priority, lowest index wins and `last` is unused. A continuously requesting requester 0 starves all others.
- `SEQ_SCHED_FIXED_PRIO_EN` undefined (default): round-robin as in Operation.

## Structure
- Package `seq_sched_pkg`: state enum (`IDLE`, `SHIFT`, `REPORT`), default `PATTERN`/`PAT_W` constants, and a `hit_count` width helper function.
- Sub-module `seq_bit_detector`:
  - Contains the history shift register and pattern compare.
  - Ports: `clock`, `reset`, `clear`, `shift_en`, `bit_in`, `match`.
- Arbiter, FSM, counter and word latch live in the top module.

## Test plan
Cases 1–4 and 6 run with the default parameters.
1. Reset held low for 2 cycles with `req`=4'b1111 -> all outputs 0, no grant. After release, the first grant is 4'b0001.
2. req0 only, word 8'hB6 -> grant cycle 0. `match` high at bits k=3 and k=6. `done` at cycle 9 with `hit_count`=2, `done_id`=0.
3. req2 only, words 8'h2D and then 8'h00 -> first word `hit_count`=1 (match at k=5), second `hit_count`=0. Grants are 10 cycles apart.
4. `req`=4'b1111 held, 5 words -> grant order 0,1,2,3,0. With `SEQ_SCHED_FIXED_PRIO_EN` defined: 0,0,0,0,0.
5. `WORD_W`=8, `PAT_W`=4, `PATTERN`=4'b1111, word 8'hFF -> overlapping hits, `hit_count`=5 (maximum).
6. Reset low at cycle 4 of SHIFT -> no `done`, IDLE on the next cycle. A pending req1 is granted after release with a clean `hit_count`.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared state encoding, default pattern constants and width helper for the
// sequence detect scheduler.
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int                   DEF_PAT_W   = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

    // Wide enough to hold the maximum overlapping hit count of one word.
    function automatic int hit_count_w(input int word_w, input int pat_w);
        return $clog2(word_w - pat_w + 2);
    endfunction

endpackage

// File: rtl/seq_bit_detector.sv
// Serial pattern detector: match is combinational on the bit that completes the
// pattern; no backpressure, history advances on shift_en and is wiped by clear.
module seq_bit_detector
    import seq_sched_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic shift_en,
    input  logic bit_in,
    output logic match
);

    localparam int                FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;

    assign window = {hist, bit_in};

    // fill gates out matches formed against the zeroed history of a fresh word.
    assign match = shift_en && (fill == FULL) && (window == PATTERN);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= window[PAT_W-2:0];
            if (fill != FULL) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Shares one serial pattern detector among N_REQ requesters: grant in IDLE, WORD_W shift cycles, 1 report cycle;
// requests wait while busy. Define SEQ_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter int               N_REQ   = 4,
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [N_REQ-1:0]                       req,
    input  logic [N_REQ*WORD_W-1:0]                data,
    output logic [N_REQ-1:0]                       grant,
    output logic                                   busy,
    output logic                                   bit_out,
    output logic                                   match,
    output logic                                   done,
    output logic [$clog2(N_REQ)-1:0]               done_id,
    output logic [hit_count_w(WORD_W, PAT_W)-1:0]  hit_count
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WORD_W);
    localparam int HC_W  = hit_count_w(WORD_W, PAT_W);

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  bit_idx;
    logic [ID_W-1:0]   winner;
    logic              accept;
    logic              shift_en;

`ifdef SEQ_SCHED_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] idx;
    logic            found;

    // Search begins just after the previous winner and wraps.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((int'(last) + i) % N_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            last <= winner;
        end
    end
`endif

    // Gated by reset so no grant is offered while reset is held low.
    assign accept   = reset && (state == IDLE) && (|req);
    assign shift_en = (state == SHIFT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (bit_idx == CNT_W'(WORD_W - 1)) next_state = REPORT;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant   = '0;
        busy    = 1'b0;
        bit_out = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) grant = N_REQ'(1) << winner;
            end
            SHIFT: begin
                busy    = 1'b1;
                bit_out = word[WORD_W-1];
            end
            REPORT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // The latched word shifts left so its MSB is always the bit on the wire.
    always_ff @(posedge clock) begin
        if (!reset) begin
            word      <= '0;
            bit_idx   <= '0;
            done_id   <= '0;
            hit_count <= '0;
        end else if (accept) begin
            word      <= data[winner*WORD_W +: WORD_W];
            bit_idx   <= '0;
            done_id   <= winner;
            hit_count <= '0;
        end else if (shift_en) begin
            word    <= {word[WORD_W-2:0], 1'b0};
            bit_idx <= bit_idx + CNT_W'(1);
            if (match) begin
                hit_count <= hit_count + HC_W'(1);
            end
        end
    end

    seq_bit_detector #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_detector (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .shift_en (shift_en),
        .bit_in   (bit_out),
        .match    (match)
    );

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: default instance plus an all-ones-pattern
// instance for overlapping hits; results are scoreboarded on done.
module tb_seq_detect_scheduler;

    typedef struct {
        int id;
        int hits;
    } exp_t;

    localparam logic [3:0] PAT = 4'b1011;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        busy, bit_out, match, done;
    logic [1:0]  done_id;
    logic [2:0]  hit_count;

    logic [3:0]  req_b;
    logic [31:0] data_b;
    logic [3:0]  grant_b;
    logic        busy_b, bit_out_b, match_b, done_b;
    logic [1:0]  done_id_b;
    logic [2:0]  hit_count_b;

    always #5 clock = ~clock;

    seq_detect_scheduler dut (
        .clock(clock), .reset(reset), .req(req), .data(data), .grant(grant),
        .busy(busy), .bit_out(bit_out), .match(match), .done(done),
        .done_id(done_id), .hit_count(hit_count)
    );

    seq_detect_scheduler #(.N_REQ(4), .WORD_W(8), .PAT_W(4), .PATTERN(4'b1111)) dut_ones (
        .clock(clock), .reset(reset), .req(req_b), .data(data_b), .grant(grant_b),
        .busy(busy_b), .bit_out(bit_out_b), .match(match_b), .done(done_b),
        .done_id(done_id_b), .hit_count(hit_count_b)
    );

    function automatic int ref_hits(input logic [7:0] w, input logic [3:0] p);
        int n = 0;
        for (int k = 3; k < 8; k++) begin
            if (w[10-k -: 4] == p) n++;
        end
        return n;
    endfunction

    function automatic logic ref_match(input logic [7:0] w, input int k, input logic [3:0] p);
        if (k < 3) return 1'b0;
        return (w[10-k -: 4] == p);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_word(input int id, input logic [7:0] w);
        exp_t e;
        e.id   = id;
        e.hits = ref_hits(w, PAT);
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required done=1", name, done, n);
        end
        tick;
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding word.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done_id=%0d hit_count=%0d, required no done", done_id, hit_count);
            end else begin
                mon_e = exp_q.pop_front();
                if (done_id !== mon_e.id[1:0] || hit_count !== mon_e.hits[2:0]) begin
                    errors++;
                    $display("FAIL scoreboard: done_id=%0d hit_count=%0d, required done_id=%0d hit_count=%0d",
                             done_id, hit_count, mon_e.id, mon_e.hits);
                end
            end
        end
    end

    task automatic test_reset;
        reset  = 1'b0;
        req    = 4'b1111;
        data   = {8'h11, 8'h22, 8'h33, 8'hB6};
        req_b  = 4'b0000;
        data_b = 32'h0;
        tick;
        tick;
        checks++;
        if ({grant, busy, bit_out, match, done, done_id, hit_count} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b busy=%b bit_out=%b match=%b done=%b done_id=%0d hit_count=%0d, required all 0",
                     grant, busy, bit_out, match, done, done_id, hit_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%b, required 0001", grant);
        end
        expect_word(0, 8'hB6);
        tick;
        req = 4'b0000;
        wait_done("reset_first");
    endtask

    task automatic test_single;
        logic [7:0] w;
        w = 8'hB6;
        data[7:0] = w;
        req = 4'b0001;
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: grant=%b, required 0001", grant);
        end
        expect_word(0, w);
        tick;
        req = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (busy !== 1'b1 || bit_out !== w[7-k] || match !== ref_match(w, k, PAT)) begin
                errors++;
                $display("FAIL single_bit%0d: busy=%b bit_out=%b match=%b, required busy=1 bit_out=%b match=%b",
                         k, busy, bit_out, match, w[7-k], ref_match(w, k, PAT));
            end
            tick;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || done_id !== 2'd0 || hit_count !== 3'd2) begin
            errors++;
            $display("FAIL single_report: done=%b busy=%b done_id=%0d hit_count=%0d, required 1 1 0 2",
                     done, busy, done_id, hit_count);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit_count !== 3'd2) begin
            errors++;
            $display("FAIL single_idle_hold: busy=%b done=%b hit_count=%0d, required 0 0 2", busy, done, hit_count);
        end
    endtask

    task automatic test_back_to_back;
        int bad_grant = 0;
        data[23:16] = 8'h2D;
        req = 4'b0100;
        #1;
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_grant0: grant=%b, required 0100", grant);
        end
        expect_word(2, 8'h2D);
        tick;
        req = 4'b0000;
        data[23:16] = 8'h00;
        req = 4'b0100;
        for (int c = 1; c < 9; c++) begin
            if (grant !== 4'b0000) bad_grant++;
            tick;
        end
        checks++;
        if (bad_grant != 0 || done !== 1'b1 || hit_count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_first: busy_grants=%0d done=%b hit_count=%0d, required 0 1 1", bad_grant, done, hit_count);
        end
        tick;
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_spacing: grant=%b at cycle 10, required 0100", grant);
        end
        expect_word(2, 8'h00);
        tick;
        req = 4'b0000;
        wait_done("b2b_second");
        checks++;
        if (hit_count !== 3'd0 || done_id !== 2'd2) begin
            errors++;
            $display("FAIL b2b_second: hit_count=%0d done_id=%0d, required 0 2", hit_count, done_id);
        end
    endtask

    task automatic test_arbitration;
        int exp_id;
        int n;
        int busy_grants = 0;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        data = {8'hBB, 8'h2D, 8'h0F, 8'hB6};
        req  = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (grant === 4'b0000 && n < 20) begin
                if (busy !== 1'b1) busy_grants++;
                tick;
                n++;
            end
`ifdef SEQ_SCHED_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = g % 4;
`endif
            checks++;
            if (grant !== 4'(1 << exp_id) || busy !== 1'b0) begin
                errors++;
                $display("FAIL arb_grant%0d: grant=%b busy=%b, required grant=%b busy=0", g, grant, busy, 4'(1 << exp_id));
            end
            expect_word(exp_id, data[exp_id*8 +: 8]);
            tick;
        end
        req = 4'b0000;
        checks++;
        if (busy_grants != 0) begin
            errors++;
            $display("FAIL arb_idle_no_grant: %0d idle cycles without grant, required 0", busy_grants);
        end
        wait_done("arb_last");
    endtask

    task automatic test_reset_mid_shift;
        data[7:0]  = 8'hB6;
        data[15:8] = 8'hBB;
        req = 4'b0001;
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_grant: grant=%b, required 0001", grant);
        end
        tick;
        req = 4'b0010;
        tick;
        tick;
        tick;
        checks++;
        if (match !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_match_k3: match=%b busy=%b, required 1 1", match, busy);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || grant !== 4'b0000 || hit_count !== 3'd0) begin
            errors++;
            $display("FAIL midrst_idle: busy=%b done=%b grant=%b hit_count=%0d, required 0 0 0000 0",
                     busy, done, grant, hit_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_pending: grant=%b, required 0010", grant);
        end
        expect_word(1, 8'hBB);
        tick;
        req = 4'b0000;
        wait_done("midrst_word");
        checks++;
        if (hit_count !== 3'd2 || done_id !== 2'd1) begin
            errors++;
            $display("FAIL midrst_clean: hit_count=%0d done_id=%0d, required 2 1", hit_count, done_id);
        end
    endtask

    task automatic test_overlap;
        int n = 0;
        data_b = {24'h0, 8'hFF};
        req_b  = 4'b0001;
        #1;
        checks++;
        if (grant_b !== 4'b0001) begin
            errors++;
            $display("FAIL overlap_grant: grant=%b, required 0001", grant_b);
        end
        tick;
        req_b = 4'b0000;
        while (done_b !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (done_b !== 1'b1 || hit_count_b !== 3'd5 || done_id_b !== 2'd0) begin
            errors++;
            $display("FAIL overlap_hits: done=%b hit_count=%0d done_id=%0d, required 1 5 0", done_b, hit_count_b, done_id_b);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_arbitration;
        test_reset_mid_shift;
        test_overlap;
        tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
